// File: rtl/mem_seq_ctrl.sv
// LC3 memory-access sequencer: walks mem_state / M_Control through the
// read, indirect-read and write phases of LD/LDR/LDI/ST/STR/STI.
module mem_seq_ctrl #(
    parameter int unsigned ACC_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [15:0] memout,
    output logic [1:0]  mem_state,
    output logic        M_Control,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] ld_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IND,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    localparam logic [1:0] MS_RD   = 2'd0;
    localparam logic [1:0] MS_IND  = 2'd1;
    localparam logic [1:0] MS_WR   = 2'd2;
    localparam logic [1:0] MS_IDLE = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        is_load_q;
    logic [1:0]  ms_q;
    logic        mc_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] ld_q;

    logic dec_ok;
    logic dec_load;
    logic dec_ind;

    always_comb begin
        dec_ok   = 1'b1;
        dec_load = 1'b0;
        dec_ind  = 1'b0;
        case (opcode)
            4'b0010, 4'b0110: dec_load = 1'b1;
            4'b1010: begin
                dec_load = 1'b1;
                dec_ind  = 1'b1;
            end
            4'b0011, 4'b0111: dec_ok = 1'b1;
            4'b1011: dec_ind = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            is_load_q <= 1'b0;
            ms_q      <= MS_IDLE;
            mc_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ld_q      <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && dec_ok) begin
                        is_load_q <= dec_load;
                        cnt_q     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        mc_q      <= 1'b0;
                        if (dec_ind) begin
                            state_q <= S_IND;
                            ms_q    <= MS_IND;
                        end else if (dec_load) begin
                            state_q <= S_RD;
                            ms_q    <= MS_RD;
                        end else begin
                            state_q <= S_WR;
                            ms_q    <= MS_WR;
                        end
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                S_IND: begin
                    if (cnt_q == 4'd0) begin
                        // The pointer fetched here addresses the next phase.
                        cnt_q <= CNT_LOAD;
                        mc_q  <= 1'b1;
                        if (is_load_q) begin
                            state_q <= S_RD;
                            ms_q    <= MS_RD;
                        end else begin
                            state_q <= S_WR;
                            ms_q    <= MS_WR;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RD: begin
                    if (cnt_q == 4'd0) begin
                        ld_q    <= memout;
                        state_q <= S_FIN;
                        ms_q    <= MS_IDLE;
                        mc_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WR: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_FIN;
                        ms_q    <= MS_IDLE;
                        mc_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ms_q    <= MS_IDLE;
                    mc_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_state = ms_q;
    assign M_Control = mc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ld_data   = ld_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Randomized bench for mem_seq_ctrl: four instances with ACC_CYCLES 1..4
// checked cycle by cycle against a phase-list reference model.
module tb_mem_seq_ctrl;

    logic              clock;
    logic              reset;
    logic [3:0]        start_v;
    logic [3:0][3:0]   opcode_v;
    logic [3:0][15:0]  memout_v;
    logic [3:0][1:0]   ms_v;
    logic [3:0]        mc_v;
    logic [3:0]        busy_v;
    logic [3:0]        done_v;
    logic [3:0]        err_v;
    logic [3:0][15:0]  ld_v;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_seq_ctrl #(.ACC_CYCLES(g + 1)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .start     (start_v[g]),
            .opcode    (opcode_v[g]),
            .memout    (memout_v[g]),
            .mem_state (ms_v[g]),
            .M_Control (mc_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .err       (err_v[g]),
            .ld_data   (ld_v[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests;
    int n_fail;
    logic [15:0] exp_ld [4];

    typedef struct packed {
        logic [1:0] ms;
        logic       mc;
        logic       fin;
        logic       last_rd;
    } step_t;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 LD, 1 LDR, 2 LDI, 3 ST, 4 STR, 5 STI, -1 illegal
    function automatic int classify(input logic [3:0] op);
        case (op)
            4'b0010: return 0;
            4'b0110: return 1;
            4'b1010: return 2;
            4'b0011: return 3;
            4'b0111: return 4;
            4'b1011: return 5;
            default: return -1;
        endcase
    endfunction

    task automatic check_idle(input int k, input string tag);
        check({tag, ".ms"}, 32'(ms_v[k]), 32'd3);
        check({tag, ".mc"}, 32'(mc_v[k]), 32'd0);
        check({tag, ".busy"}, 32'(busy_v[k]), 32'd0);
        check({tag, ".done"}, 32'(done_v[k]), 32'd0);
        check({tag, ".ld"}, 32'(ld_v[k]), 32'(exp_ld[k]));
    endtask

    task automatic do_access(input int k, input logic [3:0] op,
                             input logic use_fix, input logic [15:0] fix);
        step_t q[$];
        step_t s;
        int    cls;
        int    acc;
        logic  ind;
        logic  ld;
        acc = k + 1;
        cls = classify(op);
        ind = (cls == 2) || (cls == 5);
        ld  = (cls <= 2);
        if (ind)
            for (int j = 0; j < acc; j++) q.push_back('{2'd1, 1'b0, 1'b0, 1'b0});
        for (int j = 0; j < acc; j++) begin
            if (ld) q.push_back('{2'd0, ind, 1'b0, (j == acc - 1)});
            else    q.push_back('{2'd2, ind, 1'b0, 1'b0});
        end
        q.push_back('{2'd3, 1'b0, 1'b1, 1'b0});

        @(negedge clock);
        start_v[k]  = 1'b1;
        opcode_v[k] = op;
        @(posedge clock);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clock);
            s = q[i];
            check("acc.ms", 32'(ms_v[k]), 32'(s.ms));
            check("acc.mc", 32'(mc_v[k]), 32'(s.mc));
            check("acc.busy", 32'(busy_v[k]), 32'd1);
            check("acc.done", 32'(done_v[k]), 32'(s.fin));
            check("acc.err", 32'(err_v[k]), 32'd0);
            check("acc.ld", 32'(ld_v[k]), 32'(exp_ld[k]));
            memout_v[k] = use_fix ? fix : 16'($urandom);
            if (s.last_rd) exp_ld[k] = memout_v[k];
            if (s.fin) begin
                start_v[k] = 1'b0;
            end else begin
                // Noise on start/opcode while busy must be ignored.
                start_v[k]  = 1'($urandom);
                opcode_v[k] = 4'($urandom);
            end
        end
        @(negedge clock);
        check_idle(k, "post");
    endtask

    task automatic do_illegal(input int k, input logic [3:0] op);
        @(negedge clock);
        start_v[k]  = 1'b1;
        opcode_v[k] = op;
        @(posedge clock);
        @(negedge clock);
        check("ill.err", 32'(err_v[k]), 32'd1);
        check_idle(k, "ill");
        start_v[k] = 1'b0;
        @(negedge clock);
        check("ill.err_clr", 32'(err_v[k]), 32'd0);
        check_idle(k, "ill2");
    endtask

    logic [3:0] legal [6];
    logic [3:0] op_r;
    int         k_r;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        legal    = '{4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011};
        reset    = 1'b0;
        start_v  = '0;
        opcode_v = '0;
        memout_v = '0;
        for (int k = 0; k < 4; k++) exp_ld[k] = 16'h0000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            check_idle(k, "rst");
            check("rst.err", 32'(err_v[k]), 32'd0);
        end
        reset = 1'b1;

        do_access(1, 4'b0010, 1'b1, 16'hBEEF);
        check("ld.beef", 32'(ld_v[1]), 32'hBEEF);
        do_access(0, 4'b1010, 1'b0, 16'h0000);
        do_access(2, 4'b1011, 1'b0, 16'h0000);
        do_illegal(0, 4'b0000);
        do_access(3, 4'b0011, 1'b0, 16'h0000);

        for (int n = 0; n < 60; n++) begin
            k_r = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                do begin
                    op_r = 4'($urandom);
                end while (classify(op_r) != -1);
                do_illegal(k_r, op_r);
            end else begin
                op_r = legal[$urandom_range(0, 5)];
                do_access(k_r, op_r, 1'b0, 16'h0000);
            end
        end

        // Abort an ST in its write phase with an asynchronous reset.
        @(negedge clock);
        start_v[3]  = 1'b1;
        opcode_v[3] = 4'b0011;
        @(posedge clock);
        @(negedge clock);
        start_v[3] = 1'b0;
        check("abort.ms_wr", 32'(ms_v[3]), 32'd2);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) exp_ld[k] = 16'h0000;
        for (int k = 0; k < 4; k++) check_idle(k, "abort");
        @(negedge clock);
        reset = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("abort.nodone", 32'(done_v[3]), 32'd0);
            check("abort.busy", 32'(busy_v[3]), 32'd0);
        end
        do_access(3, 4'b0110, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
